ps2_dir_decoder: RTL
====================

PS2_DIR_DECODER -- requirements
Module: ps2_dir_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the number of idle clocks after a prefix byte (E0/F0) before the prefix is abandoned.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ps2_key_pressed  input  1  byte-valid level from the PS/2 receiver; ps2_out is valid while high.
REQ-005 SHALL have port ps2_out  input  8  received scan-code byte.
REQ-006 SHALL have ports upSig, rightSig, downSig, leftSig  output  1 each  player 0 direction, at most one high.
REQ-007 SHALL have ports upSig2, rightSig2, downSig2, leftSig2  output  1 each  player 1 direction, at most one high.
REQ-008 SHALL have port seq_error  output  1  one-cycle pulse when a prefix times out.

Function
REQ-009 SHALL consume one byte per rising edge of ps2_key_pressed: the clock where the input is 1 and its registered previous sample is 0; a multi-cycle high level counts once.
REQ-010 SHALL run a parser FSM with states IDLE, EXT, BRK and EXT_BRK.
REQ-011 SHALL apply these transitions on each consumed byte:
  - IDLE: E0->EXT; F0->BRK; otherwise a make with ext=0, staying in IDLE.
  - EXT: F0->EXT_BRK; E0->EXT; otherwise a make with ext=1, ->IDLE.
  - BRK: E0->EXT_BRK; otherwise a break with ext=0, ->IDLE.
  - EXT_BRK: any byte is a break with ext=1, ->IDLE.
REQ-012 SHALL map player 0 keys with ext=1: 75 up, 74 right, 72 down, 6B left.
REQ-013 SHALL map player 1 keys with ext=0: 1D up (W), 23 right (D), 1B down (S), 1C left (A).
REQ-014 SHALL ignore unmapped codes and mapped codes with the wrong ext flag: no held-bit change, while still completing the FSM transition.
REQ-015 SHALL keep a 4-bit held bitmap per player; a make sets the bit, a break clears it, and repeated makes (typematic) are idempotent.
REQ-016 SHALL keep a 2-bit last register and a last_valid bit per player, updated on every mapped make.
REQ-017 SHALL select each player's direction as:
  - the last key, if last_valid and that key is still held;
  - else the highest-priority held key, in the order up > right > down > left;
  - else none (all four outputs 0).
REQ-018 SHALL clear last_valid when the last key is released.
REQ-019 SHALL register all direction outputs: they reflect a consumed byte exactly 1 clock after the consuming edge.
REQ-020 SHALL use a timeout counter that:
  - clears on every consumed byte;
  - counts while the FSM is not in IDLE;
  - on reaching TIMEOUT_CYCLES-1, returns the FSM to IDLE, pulses seq_error for 1 clock and leaves the bitmaps unchanged.
REQ-021 SHALL saturate the timeout counter rather than wrap; it is 17 bits wide at the default.
REQ-022 SHALL process each player independently; a byte affects at most one player.
REQ-023 SHALL give precedence to a byte consumed on the same clock as the timeout: the byte is processed from the current state and no seq_error is raised.

Reset
REQ-024 SHALL, while reset=0, asynchronously force FSM=IDLE, bitmaps=0, last_valid=0, counter=0, previous-strobe sample=0, and all outputs=0.
REQ-025 SHALL discard any partially received sequence on reset mid-sequence; the first byte after release is parsed from IDLE.
REQ-026 SHALL, after reset release, treat a ps2_key_pressed already high as a rising edge on the first clock.

Verification
REQ-027 SHALL cover: bytes E0,75 -> upSig=1 one clock after the 75 edge; then E0,F0,75 -> upSig=0, all player 0 outputs 0.
REQ-028 SHALL cover: 1D make, then 23 make -> rightSig2=1 only; then F0,23 -> upSig2=1 via fallback.
REQ-029 SHALL cover: ps2_key_pressed held high for 5 clocks with byte 1B -> a single make, downSig2=1; then F0,1B -> 0.
REQ-030 SHALL cover: lone F0 followed by no byte for TIMEOUT_CYCLES (set to 16 in the bench) -> seq_error pulses once; next byte 1C -> leftSig2=1, treated as a make, not a break.
REQ-031 SHALL cover: byte 75 without E0 -> no output change; byte E0,1D -> no output change.
REQ-032 SHALL cover: E0,6B held, reset pulsed low mid-sequence after E0 of the next E0,F0,6B -> all outputs 0 immediately; after release, byte 6B alone -> no change.

Source files
------------

// File: rtl/ps2_dir_decoder.sv
// PS/2 scan-code parser mapping arrow keys (player 0) and WASD (player 1) to one-hot directions.
// Directions and seq_error are registered, updating at the byte's consuming edge; no backpressure, one byte per strobe edge.
module ps2_dir_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_key_pressed,
   input  logic [7:0] ps2_out,
   output logic       upSig,
   output logic       rightSig,
   output logic       downSig,
   output logic       leftSig,
   output logic       upSig2,
   output logic       rightSig2,
   output logic       downSig2,
   output logic       leftSig2,
   output logic       seq_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   // Direction index: 0 up, 1 right, 2 down, 3 left.
   typedef struct packed {
      logic [3:0] held;
      logic [1:0] last;
      logic       lv;
   } ply_t;

   state_t           state, state_nxt;
   logic             strobe_q;
   logic             consume;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             timeout;
   logic             is_make, is_break, ext;
   logic             hit0, hit1;
   logic [1:0]       idx0, idx1;
   ply_t             p0_q, p1_q, p0_nxt, p1_nxt;
   logic [3:0]       dir0_q, dir1_q;

   function automatic ply_t ply_update(input ply_t cur, input logic hit, input logic [1:0] idx,
                                       input logic mk, input logic brk);
      ply_update = cur;
      if (hit && mk) begin
         ply_update.held[idx] = 1'b1;
         ply_update.last      = idx;
         ply_update.lv        = 1'b1;
      end else if (hit && brk) begin
         ply_update.held[idx] = 1'b0;
         if (cur.last == idx) ply_update.lv = 1'b0;
      end
   endfunction

   function automatic logic [3:0] ply_dir(input ply_t p);
      ply_dir = 4'b0000;
      if (p.lv && p.held[p.last]) ply_dir[p.last] = 1'b1;
      else if (p.held[0])         ply_dir = 4'b0001;
      else if (p.held[1])         ply_dir = 4'b0010;
      else if (p.held[2])         ply_dir = 4'b0100;
      else if (p.held[3])         ply_dir = 4'b1000;
   endfunction

   assign consume = ps2_key_pressed & ~strobe_q;

   // A byte on the timeout clock wins over the timeout.
   always_comb begin
      state_nxt = state;
      is_make   = 1'b0;
      is_break  = 1'b0;
      ext       = 1'b0;
      timeout   = 1'b0;
      if (consume) begin
         case (state)
            IDLE: begin
               if (ps2_out == 8'hE0)      state_nxt = EXT;
               else if (ps2_out == 8'hF0) state_nxt = BRK;
               else                       is_make   = 1'b1;
            end
            EXT: begin
               if (ps2_out == 8'hF0)      state_nxt = EXT_BRK;
               else if (ps2_out == 8'hE0) state_nxt = EXT;
               else begin
                  is_make   = 1'b1;
                  ext       = 1'b1;
                  state_nxt = IDLE;
               end
            end
            BRK: begin
               if (ps2_out == 8'hE0) state_nxt = EXT_BRK;
               else begin
                  is_break  = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: begin
               is_break  = 1'b1;
               ext       = 1'b1;
               state_nxt = IDLE;
            end
         endcase
      end else if (state != IDLE && cnt_q == CNT_LAST) begin
         timeout   = 1'b1;
         state_nxt = IDLE;
      end
   end

   always_comb begin
      cnt_nxt = cnt_q;
      if (consume || state == IDLE) cnt_nxt = '0;
      else if (cnt_q != CNT_MAX)    cnt_nxt = cnt_q + CNT_ONE;
   end

   always_comb begin
      hit0 = 1'b0;
      idx0 = 2'd0;
      hit1 = 1'b0;
      idx1 = 2'd0;
      case (ps2_out)
         8'h75: begin hit0 = ext;  idx0 = 2'd0; end
         8'h74: begin hit0 = ext;  idx0 = 2'd1; end
         8'h72: begin hit0 = ext;  idx0 = 2'd2; end
         8'h6B: begin hit0 = ext;  idx0 = 2'd3; end
         8'h1D: begin hit1 = ~ext; idx1 = 2'd0; end
         8'h23: begin hit1 = ~ext; idx1 = 2'd1; end
         8'h1B: begin hit1 = ~ext; idx1 = 2'd2; end
         8'h1C: begin hit1 = ~ext; idx1 = 2'd3; end
         default: ;
      endcase
      p0_nxt = ply_update(p0_q, hit0, idx0, is_make, is_break);
      p1_nxt = ply_update(p1_q, hit1, idx1, is_make, is_break);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         strobe_q  <= 1'b0;
         cnt_q     <= '0;
         p0_q      <= '0;
         p1_q      <= '0;
         dir0_q    <= '0;
         dir1_q    <= '0;
         seq_error <= 1'b0;
      end else begin
         state     <= state_nxt;
         strobe_q  <= ps2_key_pressed;
         cnt_q     <= cnt_nxt;
         p0_q      <= p0_nxt;
         p1_q      <= p1_nxt;
         dir0_q    <= ply_dir(p0_nxt);
         dir1_q    <= ply_dir(p1_nxt);
         seq_error <= timeout;
      end
   end

   assign {leftSig,  downSig,  rightSig,  upSig}  = dir0_q;
   assign {leftSig2, downSig2, rightSig2, upSig2} = dir1_q;

endmodule
